// File: rtl/mpmc9_pkg.sv
// Shared mpmc9 definitions: command encodings, address width, app-side transfer structs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mpmc9_pkg;

    // Byte-address MSB of the app_addr bus.
    localparam int AMSB = 28;

    // MIG app_cmd encodings. There is no NOP encoding: a command slot is
    // either a read or a write, and any other value is a protocol error.
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    // Default data beat width used by the write-data struct.
    localparam int MPMC9_DW = 128;

    // One queued command: encoding plus address (word address, zero-extended).
    typedef struct packed {
        logic [2:0]    cmd;
        logic [AMSB:0] addr;
    } mpmc9_app_cmd_t;

    // One write-data beat with its byte mask (1 = keep the old byte).
    typedef struct packed {
        logic [MPMC9_DW-1:0]   data;
        logic [MPMC9_DW/8-1:0] mask;
    } mpmc9_wdf_t;

    typedef enum logic {
        ST_CAL = 1'b0,
        ST_RUN = 1'b1
    } mig_state_e;

endpackage

// File: rtl/mpmc9_sync_fifo.sv
// Generic synchronous FIFO with full/empty/count; pointers one bit wider than the index.
// Latency: data pushed at edge N is visible on data_o after edge N when it is at the head.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
// Ports: clk_i/rst_ni, push_i/data_i, pop_i/data_o, full_o, empty_o, count_o.
module mpmc9_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign count_o = wptr_q - rptr_q;
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (wptr_q == rptr_q);
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    // When full, a simultaneous pop frees the head slot at the same edge the
    // push overwrites it; the head value has already been consumed from data_o.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/mpmc9_mig_responder.sv
// BRAM-backed responder for the MIG app_* interface: queues commands and write beats, executes in order.
// Latency: read accepted at edge T returns app_rd_data_valid after edge T+1+RD_LAT.
// Backpressure: registered app_rdy (cmd queue space, periodic stall) and app_wdf_rdy; reads never stall.
// Ports: clk_i/rst_ni, init_calib_complete, app_en/cmd/addr/rdy, app_wdf_*, app_rd_data/_valid/_end.
module mpmc9_mig_responder
    import mpmc9_pkg::*;
#(
    parameter int DW           = 128,
    parameter int MEM_AW       = 12,
    parameter int CQ_DEPTH     = 4,
    parameter int WQ_DEPTH     = 4,
    parameter int RD_LAT       = 6,
    parameter int CAL_CYCLES   = 64,
    parameter int STALL_PERIOD = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              init_calib_complete,
    input  logic              app_en,
    input  logic [2:0]        app_cmd,
    input  logic [AMSB:0]     app_addr,
    output logic              app_rdy,
    input  logic              app_wdf_wren,
    input  logic              app_wdf_end,
    input  logic [DW-1:0]     app_wdf_data,
    input  logic [DW/8-1:0]   app_wdf_mask,
    output logic              app_wdf_rdy,
    output logic [DW-1:0]     app_rd_data,
    output logic              app_rd_data_valid,
    output logic              app_rd_data_end
);
    localparam int CQ_AW = $clog2(CQ_DEPTH);
    localparam int WQ_AW = $clog2(WQ_DEPTH);
    localparam int CQ_W  = $bits(mpmc9_app_cmd_t);
    localparam int WQ_W  = DW + DW/8;
    localparam int CAL_W = $clog2(CAL_CYCLES + 1);
    localparam int SP_W  = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    mig_state_e       state_q, state_d;
    logic [CAL_W-1:0] cal_cnt_q, cal_cnt_d;
    logic [SP_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic             stall_nxt;
    logic             app_rdy_q, app_rdy_d;
    logic             wdf_rdy_q, wdf_rdy_d;
    logic [7:0]       err_cnt_q;

    // ---------------- queues ----------------
    mpmc9_app_cmd_t   cq_din, cq_head;
    logic [CQ_W-1:0]  cq_dout;
    logic             cq_push, cq_pop, cq_full, cq_empty;
    logic [CQ_AW:0]   cq_cnt, cq_cnt_nxt;

    logic [WQ_W-1:0]  wq_dout;
    logic             wq_push, wq_pop, wq_full, wq_empty;
    logic [WQ_AW:0]   wq_cnt, wq_cnt_nxt;
    logic [DW-1:0]    wq_data;
    logic [DW/8-1:0]  wq_mask;

    // Byte offset and address bits above the RAM are dropped, so the RAM aliases.
    assign cq_din  = '{cmd: app_cmd, addr: (AMSB+1)'(app_addr[MEM_AW+3:4])};
    assign cq_push = app_en && app_rdy_q;
    assign wq_push = app_wdf_wren && wdf_rdy_q;

    mpmc9_sync_fifo #(.WIDTH(CQ_W), .DEPTH(CQ_DEPTH)) u_cmd_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cq_push),
        .data_i  (cq_din),
        .pop_i   (cq_pop),
        .data_o  (cq_dout),
        .full_o  (cq_full),
        .empty_o (cq_empty),
        .count_o (cq_cnt)
    );

    mpmc9_sync_fifo #(.WIDTH(WQ_W), .DEPTH(WQ_DEPTH)) u_wdf_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (wq_push),
        .data_i  ({app_wdf_data, app_wdf_mask}),
        .pop_i   (wq_pop),
        .data_o  (wq_dout),
        .full_o  (wq_full),
        .empty_o (wq_empty),
        .count_o (wq_cnt)
    );

    assign cq_head = mpmc9_app_cmd_t'(cq_dout);
    assign wq_data = wq_dout[WQ_W-1 -: DW];
    assign wq_mask = wq_dout[DW/8-1:0];

    // ---------------- in-order execution of the queue head ----------------
    logic              head_wr, head_rd, rd_exec, bad_exec;
    logic [MEM_AW-1:0] head_addr;

    assign head_addr = cq_head.addr[MEM_AW-1:0];
    assign head_wr   = (cq_head.cmd == CMD_WRITE);
    assign head_rd   = (cq_head.cmd == CMD_READ);
    // A write head blocks until its data beat is present; everything else pops at once.
    assign cq_pop    = !cq_empty && (!head_wr || !wq_empty);
    assign wq_pop    = !cq_empty && head_wr && !wq_empty;
    assign rd_exec   = !cq_empty && head_rd;
    assign bad_exec  = !cq_empty && !head_wr && !head_rd;

    assign cq_cnt_nxt = cq_cnt + (CQ_AW+1)'(cq_push) - (CQ_AW+1)'(cq_pop);
    assign wq_cnt_nxt = wq_cnt + (WQ_AW+1)'(wq_push) - (WQ_AW+1)'(wq_pop);

    // ---------------- calibration FSM, stall counter, ready registers ----------------
    always_comb begin
        state_d     = state_q;
        cal_cnt_d   = cal_cnt_q;
        stall_cnt_d = '0;
        case (state_q)
            ST_CAL: begin
                if (cal_cnt_q == CAL_W'(CAL_CYCLES - 1)) state_d = ST_RUN;
                else                                     cal_cnt_d = cal_cnt_q + 1'b1;
            end
            ST_RUN: begin
                if (STALL_PERIOD > 1 && stall_cnt_q != SP_W'(STALL_PERIOD - 1))
                    stall_cnt_d = stall_cnt_q + 1'b1;
            end
            default: state_d = ST_CAL;
        endcase
        // Ready is registered, so it is computed from next-cycle occupancy and stall phase.
        stall_nxt = (STALL_PERIOD != 0) && (stall_cnt_d == '0);
        app_rdy_d = (state_q == ST_RUN) && (cq_cnt_nxt != (CQ_AW+1)'(CQ_DEPTH)) && !stall_nxt;
        wdf_rdy_d = (state_q == ST_RUN) && (wq_cnt_nxt != (WQ_AW+1)'(WQ_DEPTH));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_CAL;
            cal_cnt_q   <= '0;
            stall_cnt_q <= '0;
            app_rdy_q   <= 1'b0;
            wdf_rdy_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cal_cnt_q   <= cal_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            app_rdy_q   <= app_rdy_d;
            wdf_rdy_q   <= wdf_rdy_d;
            if (bad_exec && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign init_calib_complete = (state_q == ST_RUN);
    assign app_rdy             = app_rdy_q;
    assign app_wdf_rdy         = wdf_rdy_q;

    // ---------------- RAM with byte-enable writes ----------------
    logic [DW-1:0] mem [2**MEM_AW];
    logic [DW-1:0] ram_rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_ni && wq_pop) begin
            for (int b = 0; b < DW/8; b++) begin
                if (!wq_mask[b]) mem[head_addr][b*8 +: 8] <= wq_data[b*8 +: 8];
            end
        end
        if (rd_exec) ram_rdata_q <= mem[head_addr];
    end

    // ---------------- read latency pipe ----------------
    // Stage 0 is the RAM read edge; data stages load only behind a valid.
    logic [RD_LAT:0] rd_vld_q;
    logic [DW-1:0]   rd_dat_q [1:RD_LAT];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_vld_q <= '0;
            for (int k = 1; k <= RD_LAT; k++) rd_dat_q[k] <= '0;
        end else begin
            rd_vld_q <= {rd_vld_q[RD_LAT-1:0], rd_exec};
            if (rd_vld_q[0]) rd_dat_q[1] <= ram_rdata_q;
            for (int k = 2; k <= RD_LAT; k++) begin
                if (rd_vld_q[k-1]) rd_dat_q[k] <= rd_dat_q[k-1];
            end
        end
    end

    assign app_rd_data       = rd_dat_q[RD_LAT];
    assign app_rd_data_valid = rd_vld_q[RD_LAT];
    assign app_rd_data_end   = rd_vld_q[RD_LAT];

    // Multi-beat bursts are not supported; every accepted beat must be the last one.
    a_wdf_end_single_beat: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (app_wdf_wren && app_wdf_rdy) |-> app_wdf_end);

    logic unused_ok;
    assign unused_ok = ^{app_addr[AMSB:MEM_AW+4], app_addr[3:0], cq_head.addr[AMSB:MEM_AW],
                         cq_full, wq_full, app_wdf_end};

endmodule
